// File: rtl/pcie_app_pkg.sv
// Shared types and constants for the PCIe application-side DPL buffer logic.
package pcie_app_pkg;

  // Beats in one 4 KB block (256-bit beats)
  localparam int unsigned BLK_BEATS_4K = 128;

  // One data beat on the DPL buffer write path
  typedef logic [255:0] beat_t;

  // Block arbiter states
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_XFER  = 2'd3
  } arb_state_e;

  // True when more than one bit of a (zero-extended) valid vector is set
  function automatic logic multi_hot(input logic [15:0] vec);
    return (vec & (vec - 16'd1)) != 16'd0;
  endfunction

endpackage

// File: rtl/pcie_rr_arb.sv
// Pure combinational round-robin pick: the first set request at or after ptr wins.
module pcie_rr_arb #(
  parameter int unsigned pNUM_REQ = 4
) (
  input  logic [pNUM_REQ-1:0] req,
  input  logic [3:0]          ptr,
  input  logic                en,
  output logic [pNUM_REQ-1:0] gnt,
  output logic [3:0]          idx,
  output logic                vld
);

  logic [2*pNUM_REQ-1:0] rot_s;
  logic [4:0]            sum_s;

  // Rotate requests so ptr lands on bit 0, take the lowest set bit, map back
  always_comb begin
    gnt   = '0;
    idx   = 4'd0;
    vld   = 1'b0;
    sum_s = 5'd0;
    rot_s = {req, req} >> ptr;
    for (int i = 0; i < int'(pNUM_REQ); i++) begin
      if (en && !vld && rot_s[i]) begin
        vld   = 1'b1;
        sum_s = 5'(ptr) + 5'(i);
        if (sum_s >= 5'(pNUM_REQ)) begin
          sum_s = sum_s - 5'(pNUM_REQ);
        end else begin
          sum_s = sum_s;
        end
        idx = sum_s[3:0];
      end else begin
        vld = vld;
      end
    end
    if (vld) begin
      gnt = pNUM_REQ'(1'b1) << idx;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/pcie_dplbuf_arb.sv
// Round-robin block arbiter and beat merger in front of the DPL buffer write port.
module pcie_dplbuf_arb
  import pcie_app_pkg::*;
#(
  parameter int unsigned pNUM_LINK  = 4,
  parameter int unsigned pBLK_BEATS = BLK_BEATS_4K,
  parameter int unsigned pWAIT_TMO  = 256
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic [pNUM_LINK-1:0]          iREQ,
  output logic [pNUM_LINK-1:0]          oGNT,
  output logic                          oANY_DATA_V,
  input  logic [pNUM_LINK-1:0][255:0]   iDATA,
  input  logic [pNUM_LINK-1:0]          iDATA_V,
  input  logic [15:0]                   iFREE_BEATS,
  output logic [255:0]                  oDATA,
  output logic                          oDATA_V,
  output logic                          oSOP,
  output logic                          oEOP,
  output logic [3:0]                    oLINK,
  output logic                          oERR,
  output logic [31:0]                   oBLK_CNT
);

  localparam logic [7:0] CNT_LAST = 8'(pBLK_BEATS - 1);
  localparam logic [8:0] TMO_LAST = 9'(pWAIT_TMO - 1);
  localparam logic [3:0] PTR_LAST = 4'(pNUM_LINK - 1);

  arb_state_e           state_r;
  logic [3:0]           owner_r;
  logic [pNUM_LINK-1:0] owner_oh_r;
  logic [3:0]           ptr_r;
  logic [8:0]           tmr_r;
  logic [7:0]           cnt_r;
  logic [pNUM_LINK-1:0] gnt_r;
  logic                 any_v_r;
  beat_t                data_r;
  logic                 data_v_r;
  logic                 sop_r;
  logic                 eop_r;
  logic [3:0]           link_r;
  logic                 err_r;
  logic [31:0]          blk_cnt_r;

  beat_t                merged_s;
  logic                 any_v_s;
  logic                 own_v_s;
  logic                 busy_s;
  logic                 beat_err_s;
  logic                 tmo_s;
  logic                 own_beat_s;
  logic                 last_s;
  logic                 sop_s;
  logic                 eop_s;
  logic                 arb_en_s;
  logic [pNUM_LINK-1:0] win_oh_s;
  logic [3:0]           win_idx_s;
  logic                 win_vld_s;

  // Grants are only considered from IDLE and only with room for a whole block
  assign arb_en_s = (state_r == ARB_IDLE) && (iFREE_BEATS >= 16'(pBLK_BEATS));

  pcie_rr_arb #(
    .pNUM_REQ (pNUM_LINK)
  ) u_rr_arb (
    .req (iREQ),
    .ptr (ptr_r),
    .en  (arb_en_s),
    .gnt (win_oh_s),
    .idx (win_idx_s),
    .vld (win_vld_s)
  );

  // Merge the zero-when-idle buses and classify the current input beat
  always_comb begin
    merged_s = '0;
    for (int i = 0; i < int'(pNUM_LINK); i++) begin
      merged_s = merged_s | (iDATA[i] & {256{iDATA_V[i]}});
    end
    any_v_s    = |iDATA_V;
    own_v_s    = |(iDATA_V & owner_oh_r);
    busy_s     = (state_r == ARB_WAIT) || (state_r == ARB_XFER);
    beat_err_s = any_v_s && (!busy_s || (|(iDATA_V & ~owner_oh_r)) ||
                             multi_hot(16'(iDATA_V)));
    // A first beat arriving on the last WAIT cycle takes precedence over the timeout
    tmo_s      = (state_r == ARB_WAIT) && !own_v_s && (tmr_r == TMO_LAST);
    own_beat_s = busy_s && own_v_s;
    last_s     = own_beat_s && (cnt_r == CNT_LAST);
    sop_s      = own_beat_s && !beat_err_s && (cnt_r == 8'd0);
    eop_s      = last_s && !beat_err_s;
  end

  // Block FSM: grant pulse, owner latch, round-robin pointer, WAIT timer, beat counter
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_r    <= ARB_IDLE;
      owner_r    <= 4'd0;
      owner_oh_r <= '0;
      ptr_r      <= 4'd0;
      tmr_r      <= 9'd0;
      cnt_r      <= 8'd0;
      gnt_r      <= '0;
    end else begin
      gnt_r <= '0;
      case (state_r)
        ARB_IDLE: begin
          cnt_r <= 8'd0;
          if (win_vld_s) begin
            state_r    <= ARB_GRANT;
            gnt_r      <= win_oh_s;
            owner_r    <= win_idx_s;
            owner_oh_r <= win_oh_s;
            ptr_r      <= (win_idx_s == PTR_LAST) ? 4'd0 : win_idx_s + 4'd1;
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_GRANT: begin
          tmr_r   <= 9'd0;
          cnt_r   <= 8'd0;
          state_r <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (own_v_s) begin
            cnt_r   <= last_s ? 8'd0 : cnt_r + 8'd1;
            state_r <= last_s ? ARB_IDLE : ARB_XFER;
          end else if (tmo_s) begin
            state_r <= ARB_IDLE;
          end else begin
            tmr_r <= (tmr_r == 9'h1FF) ? tmr_r : tmr_r + 9'd1;
          end
        end
        ARB_XFER: begin
          if (own_v_s) begin
            cnt_r   <= last_s ? 8'd0 : cnt_r + 8'd1;
            state_r <= last_s ? ARB_IDLE : ARB_XFER;
          end else begin
            state_r <= ARB_XFER;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

  // Registered merged beat, framing, error pulse and completed-block counter
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      any_v_r   <= 1'b0;
      data_r    <= '0;
      data_v_r  <= 1'b0;
      sop_r     <= 1'b0;
      eop_r     <= 1'b0;
      link_r    <= 4'd0;
      err_r     <= 1'b0;
      blk_cnt_r <= 32'd0;
    end else begin
      any_v_r   <= any_v_s;
      data_r    <= merged_s;
      data_v_r  <= any_v_s;
      sop_r     <= sop_s;
      eop_r     <= eop_s;
      link_r    <= owner_r;
      err_r     <= beat_err_s || tmo_s;
      blk_cnt_r <= blk_cnt_r + 32'(eop_s);
    end
  end

  assign oGNT        = gnt_r;
  assign oANY_DATA_V = any_v_r;
  assign oDATA       = data_r;
  assign oDATA_V     = data_v_r;
  assign oSOP        = sop_r;
  assign oEOP        = eop_r;
  assign oLINK       = link_r;
  assign oERR        = err_r;
  assign oBLK_CNT    = blk_cnt_r;

endmodule
